// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the load/store unit: word type, FSM states,
// funct3 size encodings, alignment and byte-strobe helpers.
package load_store_unit_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  // Illegal size encodings report as not aligned so they take the reject path.
  function automatic logic lsu_aligned(input logic [2:0] f3, input logic [1:0] lo);
    logic ok;
    case (f3)
      LSU_B, LSU_BU: ok = 1'b1;
      LSU_H, LSU_HU: ok = (lo[0] == 1'b0);
      LSU_W:         ok = (lo == 2'b00);
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] lsu_strb(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] strb;
    case (f3)
      LSU_B, LSU_BU: strb = 4'b0001 << lo;
      LSU_H, LSU_HU: strb = 4'b0011 << lo;
      LSU_W:         strb = 4'b1111;
      default:       strb = 4'b0000;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Memory-side bus of the load/store unit; master is the LSU, slave the memory.
interface load_store_unit_if;
  import load_store_unit_pkg::*;

  logic       bus_req;
  logic       bus_we;
  word_t      bus_addr;
  logic [3:0] bus_wstrb;
  word_t      bus_wdata;
  logic       bus_gnt;
  logic       bus_rvalid;
  word_t      bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );

endinterface

// File: rtl/load_store_unit_load_align.sv
// Combinational load extraction: pick the byte/half at the access offset and
// sign- or zero-extend it according to funct3.
module lsu_load_align
  import load_store_unit_pkg::*;
(
  input  word_t       i_raw,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  output word_t       o_data
);

  word_t w_shifted;

  // Shift the addressed lane down to bit 0, then extend by size/sign.
  always_comb begin
    w_shifted = i_raw >> {i_offset, 3'b000};
    case (i_funct3)
      LSU_B:   o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      LSU_BU:  o_data = {24'h00_0000, w_shifted[7:0]};
      LSU_H:   o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      LSU_HU:  o_data = {16'h0000, w_shifted[15:0]};
      LSU_W:   o_data = i_raw;
      default: o_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns one datapath access per instruction into a
// request/grant/read-valid bus transaction with alignment check and timeout.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mem_valid,
  input  logic       mem_write,
  input  logic [2:0] funct3,
  input  word_t      addr,
  input  word_t      wdata,
  output word_t      rdata,
  output logic       stall,
  output logic       misaligned,
  output logic       bus_error,
  load_store_unit_if.master bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  lsu_state_e  r_state;
  logic [CW-1:0] r_cnt;
  word_t       r_rdata;
  logic        r_misaligned;
  logic        r_bus_error;
  logic        r_bus_req;
  logic        r_bus_we;
  word_t       r_bus_addr;
  logic [3:0]  r_bus_wstrb;
  word_t       r_bus_wdata;
  logic [2:0]  r_funct3;
  logic [1:0]  r_offset;

  logic        w_aligned;
  logic        w_timeout;
  word_t       w_load_data;

  assign w_aligned = lsu_aligned(funct3, addr[1:0]);
  assign w_timeout = (r_cnt == CNT_LAST);

  lsu_load_align u_load_align (
    .i_raw    (bus.bus_rdata),
    .i_offset (r_offset),
    .i_funct3 (r_funct3),
    .o_data   (w_load_data)
  );

  // Stall must rise in the accepting IDLE cycle so the core freezes before the edge.
  always_comb begin
    if ((r_state == LSU_REQ) || (r_state == LSU_WAIT)) begin
      stall = 1'b1;
    end else if ((r_state == LSU_IDLE) && mem_valid && w_aligned) begin
      stall = 1'b1;
    end else begin
      stall = 1'b0;
    end
  end

  // Access FSM with all bus/status outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= LSU_IDLE;
      r_cnt        <= '0;
      r_rdata      <= 32'h0000_0000;
      r_misaligned <= 1'b0;
      r_bus_error  <= 1'b0;
      r_bus_req    <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_addr   <= 32'h0000_0000;
      r_bus_wstrb  <= 4'b0000;
      r_bus_wdata  <= 32'h0000_0000;
      r_funct3     <= 3'b000;
      r_offset     <= 2'b00;
    end else begin
      r_misaligned <= 1'b0;
      r_bus_error  <= 1'b0;
      case (r_state)
        LSU_IDLE: begin
          if (mem_valid) begin
            if (w_aligned) begin
              r_bus_addr  <= {addr[31:2], 2'b00};
              r_bus_we    <= mem_write;
              r_bus_wstrb <= mem_write ? lsu_strb(funct3, addr[1:0]) : 4'b0000;
              r_bus_wdata <= wdata << {addr[1:0], 3'b000};
              r_funct3    <= funct3;
              r_offset    <= addr[1:0];
              r_bus_req   <= 1'b1;
              r_cnt       <= '0;
              r_state     <= LSU_REQ;
            end else begin
              r_misaligned <= 1'b1;
            end
          end
        end
        LSU_REQ: begin
          r_cnt <= r_cnt + 1'b1;
          if (bus.bus_gnt) begin
            r_bus_req <= 1'b0;
            if (r_bus_we) begin
              r_state <= LSU_DONE;
            end else if (bus.bus_rvalid) begin
              r_rdata <= w_load_data;
              r_state <= LSU_DONE;
            end else begin
              r_state <= LSU_WAIT;
            end
          end else if (w_timeout) begin
            r_bus_req   <= 1'b0;
            r_bus_error <= 1'b1;
            r_rdata     <= 32'h0000_0000;
            r_state     <= LSU_DONE;
          end
        end
        LSU_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (bus.bus_rvalid) begin
            r_rdata <= w_load_data;
            r_state <= LSU_DONE;
          end else if (w_timeout) begin
            r_bus_error <= 1'b1;
            r_rdata     <= 32'h0000_0000;
            r_state     <= LSU_DONE;
          end
        end
        LSU_DONE: begin
          r_state <= LSU_IDLE;
        end
        default: begin
          r_state   <= LSU_IDLE;
          r_bus_req <= 1'b0;
        end
      endcase
    end
  end

  assign rdata         = r_rdata;
  assign misaligned    = r_misaligned;
  assign bus_error     = r_bus_error;
  assign bus.bus_req   = r_bus_req;
  assign bus.bus_we    = r_bus_we;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_wstrb = r_bus_wstrb;
  assign bus.bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit: stores, sign/zero-extended
// loads, alignment rejects, bus timeout and mid-transaction reset.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic       clk;
  logic       reset;
  logic       mem_valid;
  logic       mem_write;
  logic [2:0] funct3;
  word_t      addr;
  word_t      wdata;
  word_t      rdata;
  logic       stall;
  logic       misaligned;
  logic       bus_error;

  int n_checks;
  int n_errors;

  load_store_unit_if bus_if ();

  load_store_unit #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_valid  (mem_valid),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .stall      (stall),
    .misaligned (misaligned),
    .bus_error  (bus_error),
    .bus        (bus_if.master)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Starts at posedge+1; returns in the first cycle with stall low (DONE, or IDLE on reject).
  task automatic access(input logic we, input logic [2:0] f3, input word_t a, input word_t wd,
                        input int gnt_at, input int rv_after, input word_t rd,
                        output int stall_n, output logic [3:0] strb_k1, output word_t wdata_k1,
                        output word_t addr_k1, output logic req_k1);
    stall_n  = 0;
    strb_k1  = 4'b0000;
    wdata_k1 = 32'h0000_0000;
    addr_k1  = 32'h0000_0000;
    req_k1   = 1'b0;
    mem_valid = 1'b1;
    mem_write = we;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    bus_if.bus_rdata = rd;
    #1;
    for (int k = 1; k <= 40 && stall; k++) begin
      stall_n++;
      @(posedge clk);
      #1;
      mem_valid = 1'b0;
      bus_if.bus_gnt    = (k == gnt_at);
      bus_if.bus_rvalid = (gnt_at > 0) && (k == gnt_at + rv_after);
      #1;
      if (k == 1) begin
        strb_k1  = bus_if.bus_wstrb;
        wdata_k1 = bus_if.bus_wdata;
        addr_k1  = bus_if.bus_addr;
        req_k1   = bus_if.bus_req;
      end
    end
    bus_if.bus_gnt    = 1'b0;
    bus_if.bus_rvalid = 1'b0;
    check_eq("stall_bound", {31'd0, stall}, 32'd0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int         sn;
  logic [3:0] s_strb;
  word_t      s_wdata;
  word_t      s_addr;
  logic       s_req;

  initial begin
    n_checks = 0;
    n_errors = 0;
    clk = 1'b0;
    reset = 1'b0;
    mem_valid = 1'b0;
    mem_write = 1'b0;
    funct3 = 3'b000;
    addr = 32'h0000_0000;
    wdata = 32'h0000_0000;
    bus_if.bus_gnt = 1'b0;
    bus_if.bus_rvalid = 1'b0;
    bus_if.bus_rdata = 32'h0000_0000;

    #12;
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_stall", {31'd0, stall}, 32'd0);
    check_eq("rst_misal", {31'd0, misaligned}, 32'd0);
    check_eq("rst_berr", {31'd0, bus_error}, 32'd0);
    check_eq("rst_req", {31'd0, bus_if.bus_req}, 32'd0);
    check_eq("rst_we", {31'd0, bus_if.bus_we}, 32'd0);
    check_eq("rst_strb", {28'd0, bus_if.bus_wstrb}, 32'd0);
    check_eq("rst_addr", bus_if.bus_addr, 32'h0);
    check_eq("rst_wdata", bus_if.bus_wdata, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // SW 0x100, grant on the second REQ cycle
    access(1'b1, LSU_W, 32'h0000_0100, 32'hDEAD_BEEF, 2, 0, 32'h0, sn, s_strb, s_wdata, s_addr, s_req);
    check_eq("sw_stall_n", sn, 32'd3);
    check_eq("sw_addr", s_addr, 32'h0000_0100);
    check_eq("sw_strb", {28'd0, s_strb}, 32'hF);
    check_eq("sw_wdata", s_wdata, 32'hDEAD_BEEF);
    check_eq("sw_req", {31'd0, s_req}, 32'd1);
    check_eq("sw_done_req", {31'd0, bus_if.bus_req}, 32'd0);
    check_eq("sw_done_berr", {31'd0, bus_error}, 32'd0);
    next_cycle();

    // LB / LBU 0x103, rvalid one cycle after grant
    access(1'b0, LSU_B, 32'h0000_0103, 32'h0, 1, 1, 32'h80FF_0000, sn, s_strb, s_wdata, s_addr, s_req);
    check_eq("lb_stall_n", sn, 32'd3);
    check_eq("lb_strb", {28'd0, s_strb}, 32'h0);
    check_eq("lb_rdata", rdata, 32'hFFFF_FF80);
    next_cycle();
    access(1'b0, LSU_BU, 32'h0000_0103, 32'h0, 1, 1, 32'h80FF_0000, sn, s_strb, s_wdata, s_addr, s_req);
    check_eq("lbu_rdata", rdata, 32'h0000_0080);
    next_cycle();

    // SH 0x102, SB 0x101
    access(1'b1, LSU_H, 32'h0000_0102, 32'h0000_ABCD, 1, 0, 32'h0, sn, s_strb, s_wdata, s_addr, s_req);
    check_eq("sh_stall_n", sn, 32'd2);
    check_eq("sh_addr", s_addr, 32'h0000_0100);
    check_eq("sh_strb", {28'd0, s_strb}, 32'hC);
    check_eq("sh_wdata", s_wdata, 32'hABCD_0000);
    next_cycle();
    access(1'b1, LSU_B, 32'h0000_0101, 32'h0000_00AB, 1, 0, 32'h0, sn, s_strb, s_wdata, s_addr, s_req);
    check_eq("sb_strb", {28'd0, s_strb}, 32'h2);
    check_eq("sb_wdata", s_wdata, 32'h0000_AB00);
    next_cycle();

    // LW 0x101 and illegal funct3 are rejected without a bus request
    access(1'b0, LSU_W, 32'h0000_0101, 32'h0, 1, 0, 32'h0, sn, s_strb, s_wdata, s_addr, s_req);
    check_eq("mis_stall_n", sn, 32'd0);
    next_cycle();
    mem_valid = 1'b0;
    #1;
    check_eq("mis_pulse", {31'd0, misaligned}, 32'd1);
    check_eq("mis_req", {31'd0, bus_if.bus_req}, 32'd0);
    next_cycle();
    check_eq("mis_end", {31'd0, misaligned}, 32'd0);
    check_eq("mis_req2", {31'd0, bus_if.bus_req}, 32'd0);
    access(1'b0, 3'b011, 32'h0000_0100, 32'h0, 1, 0, 32'h0, sn, s_strb, s_wdata, s_addr, s_req);
    check_eq("ill_stall_n", sn, 32'd0);
    next_cycle();
    mem_valid = 1'b0;
    #1;
    check_eq("ill_pulse", {31'd0, misaligned}, 32'd1);
    next_cycle();

    // LH / LHU, read data in the grant cycle
    access(1'b0, LSU_H, 32'h0000_0102, 32'h0, 1, 0, 32'h8001_1234, sn, s_strb, s_wdata, s_addr, s_req);
    check_eq("lh_stall_n", sn, 32'd2);
    check_eq("lh_rdata", rdata, 32'hFFFF_8001);
    next_cycle();
    access(1'b0, LSU_HU, 32'h0000_0100, 32'h0, 1, 0, 32'h1234_8001, sn, s_strb, s_wdata, s_addr, s_req);
    check_eq("lhu_rdata", rdata, 32'h0000_8001);
    next_cycle();

    // LW with no grant: abort after 16 cycles in REQ
    access(1'b0, LSU_W, 32'h0000_0300, 32'h0, 0, 0, 32'h5555_5555, sn, s_strb, s_wdata, s_addr, s_req);
    check_eq("to_stall_n", sn, 32'd17);
    check_eq("to_berr", {31'd0, bus_error}, 32'd1);
    check_eq("to_rdata", rdata, 32'h0);
    check_eq("to_req", {31'd0, bus_if.bus_req}, 32'd0);
    next_cycle();
    check_eq("to_berr_end", {31'd0, bus_error}, 32'd0);
    check_eq("to_idle_stall", {31'd0, stall}, 32'd0);

    access(1'b0, LSU_W, 32'h0000_0204, 32'h0, 1, 0, 32'h1234_5678, sn, s_strb, s_wdata, s_addr, s_req);
    check_eq("lw_rdata", rdata, 32'h1234_5678);
    next_cycle();

    // Reset while waiting for read data
    mem_valid = 1'b1;
    mem_write = 1'b0;
    funct3 = LSU_W;
    addr = 32'h0000_0200;
    next_cycle();
    mem_valid = 1'b0;
    bus_if.bus_gnt = 1'b1;
    next_cycle();
    bus_if.bus_gnt = 1'b0;
    #1;
    check_eq("wait_stall", {31'd0, stall}, 32'd1);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_stall", {31'd0, stall}, 32'd0);
    check_eq("mid_rst_rdata", rdata, 32'h0);
    check_eq("mid_rst_addr", bus_if.bus_addr, 32'h0);
    check_eq("mid_rst_strb", {28'd0, bus_if.bus_wstrb}, 32'd0);
    check_eq("mid_rst_req", {31'd0, bus_if.bus_req}, 32'd0);
    next_cycle();
    reset = 1'b1;
    access(1'b0, LSU_W, 32'h0000_0208, 32'h0, 1, 0, 32'hA5A5_5A5A, sn, s_strb, s_wdata, s_addr, s_req);
    check_eq("post_rst_stall_n", sn, 32'd2);
    check_eq("post_rst_addr", s_addr, 32'h0000_0208);
    check_eq("post_rst_rdata", rdata, 32'hA5A5_5A5A);
    next_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: TIMEOUT, default 16, max cycles spent in REQ or WAIT before abort.
REQ-002 clk  input  1  single system clock, rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 mem_valid  input  1  datapath requests a data access this instruction.
REQ-005 mem_write  input  1  1 = store, 0 = load.
REQ-006 funct3  input  3  size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-007 addr  input  word_t  byte address (datapath ALUResult).
REQ-008 wdata  input  word_t  store data (datapath WriteData), right-aligned.
REQ-009 rdata  output  word_t  extended load data (datapath ReadData).
REQ-010 stall  output  1  holds the core PC and register write while high.
REQ-011 misaligned  output  1  one-cycle pulse: access rejected for alignment.
REQ-012 bus_error  output  1  one-cycle pulse: access aborted by timeout.
REQ-013 bus_req / bus_we  output  1 each  bus request, bus write enable.
REQ-014 bus_addr  output  word_t  word-aligned address (addr[1:0] forced to 00).
REQ-015 bus_wstrb  output  4  byte-lane strobes.
REQ-016 bus_wdata  output  word_t  lane-shifted store data.
REQ-017 bus_gnt / bus_rvalid  input  1 each  request accepted; read data valid.
REQ-018 bus_rdata  input  word_t  raw read word.

Function
REQ-019 Four states: IDLE, REQ, WAIT, DONE.
REQ-020 Alignment: halfword needs addr[0]=0; word needs addr[1:0]=00; byte is always aligned.
REQ-021 Illegal funct3 (011, 110, 111) is treated as misaligned.
REQ-022 IDLE, mem_valid=1 and aligned: latch addr, we, size, strobes and shifted wdata; go to REQ; stall=1 in this cycle.
REQ-023 IDLE, mem_valid=1 and misaligned: pulse misaligned, no bus_req, stall=0, stay in IDLE.
REQ-024 Strobes: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
REQ-025 bus_wdata equals wdata shifted left by 8*addr[1:0]; loads drive wstrb=0000.
REQ-026 REQ: bus_req=1 with addr/we/wstrb/wdata held stable until bus_gnt=1.
REQ-027 REQ with bus_gnt=1: a store goes to DONE.
REQ-028 REQ with bus_gnt=1: a load goes to WAIT, or to DONE if bus_rvalid=1 in the same cycle.
REQ-029 WAIT with bus_rvalid=1: capture extracted data into the rdata register; go to DONE.
REQ-030 Extraction: select the byte/half at addr[1:0]; sign-extend for LB/LH, zero-extend for LBU/LHU; LW is passthrough.
REQ-031 DONE: stall=0, rdata valid for the core write-back; unconditional return to IDLE; mem_valid ignored in DONE.
REQ-032 stall=1 throughout REQ and WAIT.
REQ-033 Timeout counter clears on entry to REQ and counts every cycle in REQ/WAIT.
REQ-034 On reaching TIMEOUT: pulse bus_error, drop bus_req, go to DONE, rdata=0.
REQ-035 bus_rvalid outside WAIT/REQ is ignored; bus_gnt outside REQ is ignored.

Reset
REQ-036 reset=0 at any time, including mid-transaction, forces IDLE within the same cycle, asynchronously.
REQ-037 Reset values: rdata=0, stall=0, misaligned=0, bus_error=0, bus_req=0, bus_we=0, bus_wstrb=0, bus_addr=0, bus_wdata=0, counter=0.
REQ-038 After reset release, the first rising edge samples mem_valid normally.

Structure
REQ-039 Shared types package holds: lsu_state_e, funct3 size constants (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU), and existing word_t.
REQ-040 One sub-module, lsu_load_align, is combinational byte/half select plus extension.

Verification
REQ-041 SW addr=0x100, wdata=0xDEADBEEF, gnt after 2 cycles -> bus_addr=0x100, wstrb=1111, stall high 3 cycles, then DONE.
REQ-042 LB addr=0x103, bus_rdata=0x80FF_0000, rvalid 1 cycle after gnt -> rdata=0xFFFFFF80; LBU -> 0x00000080.
REQ-043 SH addr=0x102, wdata=0x0000ABCD -> wstrb=1100, bus_wdata=0xABCD0000.
REQ-044 LW addr=0x101 -> misaligned pulse, bus_req never asserted, stall=0.
REQ-045 LW with gnt never asserted, TIMEOUT=16 -> bus_error after 16 cycles, rdata=0, return to IDLE.
REQ-046 Reset asserted while in WAIT -> immediate IDLE, all outputs at reset values; a later LW completes normally.
